mul_pipe_unit: RTL

//  Pipelined RV32M multiply unit with valid/ready flow control and tag passthrough; executes mul/mulh/mulhsu/mulhu.
//  Fed by the EX-stage M-extension dispatch; results return to writeback arbitration. Width and depth parametrised.

---
 rtl/mul_pipe_unit_pkg.sv | 22 ++
 rtl/mul_pp_reduce.sv | 35 +++
 rtl/mul_pipe_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_pipe_unit_pkg.sv
// M-extension decode types shared by the multiply pipeline: funct3 encoding,
// multiply-op classifier and the deepest supported pipeline.
package m_extension;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } m_funct3_e;

    localparam int MUL_STAGES_MAX = 4;

    function automatic logic is_mul_op(input m_funct3_e f);
        return f inside {F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU};
    endfunction

endpackage

// File: rtl/mul_pp_reduce.sv
// Combinational unsigned XLEN x XLEN partial-product generation, folded by a
// chain of 3:2 carry-save counters into two 2*XLEN rows whose sum is the product.
module mul_pp_reduce #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] row_top,
    output logic [2*XLEN-1:0] row_bot
);

    localparam int PW = 2 * XLEN;

    logic [PW-1:0] sum_acc;
    logic [PW-1:0] car_acc;
    logic [PW-1:0] pp;
    logic [PW-1:0] maj;

    // Carries out of bit PW-1 are dropped: the true product always fits in PW bits.
    always_comb begin
        sum_acc = '0;
        car_acc = '0;
        pp      = '0;
        maj     = '0;
        for (int i = 0; i < XLEN; i++) begin
            pp      = b[i] ? (PW'(a) << i) : '0;
            maj     = (sum_acc & car_acc) | (sum_acc & pp) | (car_acc & pp);
            sum_acc = sum_acc ^ car_acc ^ pp;
            car_acc = maj << 1;
        end
        row_top = car_acc;
        row_bot = sum_acc;
    end

endmodule

// File: rtl/mul_pipe_unit.sv
// Pipelined RV32M multiplier (mul/mulh/mulhsu/mulhu) with valid/ready at both ends,
// tag passthrough and flush. MUL_PERF_CNT_EN adds perf_ops/perf_stall counters.
module mul_pipe_unit
    import m_extension::*;
#(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 5,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
`ifdef MUL_PERF_CNT_EN
    ,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_stall
`endif
);

    localparam int S       = (STAGES < 2) ? 2 :
                             ((STAGES > MUL_STAGES_MAX) ? MUL_STAGES_MAX : STAGES);
    localparam int ROW_STG = (S == 2) ? 1 : 2;
    localparam int W2      = 2 * XLEN;

    logic [S:1]       v;
    logic [S:1]       en;
    logic [S:1]       ld;
    logic [S:0]       vin;
    logic             in_fire;

    m_funct3_e        f3_in;
    logic             sgn1, sgn2, neg_in;
    logic [XLEN-1:0]  a_in, b_in, pp_a, pp_b;
    logic [W2-1:0]    row_top, row_bot, top_q, bot_q;
    logic [W2-1:0]    sum_full, prod;
    logic [XLEN-1:0]  res_d, res_q;

    logic [TAG_W-1:0] tag_q [1:S];
    m_funct3_e        f3_q  [1:S-1];
    logic             neg_q [1:S-1];

    // A stage can take new contents whenever the output drains or any stage at or after it is empty.
    for (genvar k = 1; k <= S; k++) begin : g_adv
        assign en[k] = out_ready || !(&v[S:k]);
        assign ld[k] = en[k] && vin[k-1];
    end

    assign in_ready = en[1] && !flush;
    assign in_fire  = in_valid && in_ready;
    assign vin      = {v, in_fire};

    always_comb begin
        f3_in = m_funct3_e'(in_funct3);
        sgn1  = 1'b0;
        sgn2  = 1'b0;
        case (f3_in)
            F3_MUL, F3_MULH: begin
                sgn1 = in_rs1[XLEN-1];
                sgn2 = in_rs2[XLEN-1];
            end
            F3_MULHSU: sgn1 = in_rs1[XLEN-1];
            default: ;
        endcase
        a_in   = sgn1 ? -in_rs1 : in_rs1;
        b_in   = sgn2 ? -in_rs2 : in_rs2;
        neg_in = sgn1 ^ sgn2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int k = 1; k <= S; k++) tag_q[k] <= '0;
            for (int k = 1; k <= S - 1; k++) begin
                f3_q[k]  <= F3_MUL;
                neg_q[k] <= 1'b0;
            end
        end else begin
            if (flush) begin
                v <= '0;
            end else begin
                for (int k = 1; k <= S; k++) begin
                    if (en[k]) v[k] <= vin[k-1];
                end
            end
            if (ld[1]) begin
                tag_q[1] <= in_tag;
                f3_q[1]  <= f3_in;
                neg_q[1] <= neg_in;
            end
            for (int k = 2; k <= S; k++) begin
                if (ld[k]) tag_q[k] <= tag_q[k-1];
            end
            for (int k = 2; k <= S - 1; k++) begin
                if (ld[k]) begin
                    f3_q[k]  <= f3_q[k-1];
                    neg_q[k] <= neg_q[k-1];
                end
            end
        end
    end

    // Two-stage build folds sign conditioning straight into the partial-product stage.
    if (S == 2) begin : g_merged_cond
        assign pp_a = a_in;
        assign pp_b = b_in;
    end else begin : g_cond_reg
        logic [XLEN-1:0] a_q, b_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                a_q <= '0;
                b_q <= '0;
            end else if (ld[1]) begin
                a_q <= a_in;
                b_q <= b_in;
            end
        end
        assign pp_a = a_q;
        assign pp_b = b_q;
    end

    mul_pp_reduce #(.XLEN(XLEN)) u_pp_reduce (
        .a       (pp_a),
        .b       (pp_b),
        .row_top (row_top),
        .row_bot (row_bot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q <= '0;
            bot_q <= '0;
        end else if (ld[ROW_STG]) begin
            top_q <= row_top;
            bot_q <= row_bot;
        end
    end

    // Four-stage build registers the low-half sum and its carry before the high-half add.
    if (S == 4) begin : g_split_add
        logic [XLEN-1:0] lo_q, hi_top_q, hi_bot_q;
        logic            c_q;
        logic [XLEN:0]   lo_sum;

        assign lo_sum = {1'b0, top_q[XLEN-1:0]} + {1'b0, bot_q[XLEN-1:0]};

        always_ff @(posedge clk) begin
            if (rst) begin
                lo_q     <= '0;
                c_q      <= 1'b0;
                hi_top_q <= '0;
                hi_bot_q <= '0;
            end else if (ld[3]) begin
                lo_q     <= lo_sum[XLEN-1:0];
                c_q      <= lo_sum[XLEN];
                hi_top_q <= top_q[W2-1:XLEN];
                hi_bot_q <= bot_q[W2-1:XLEN];
            end
        end

        assign sum_full = {hi_top_q + hi_bot_q + {{(XLEN-1){1'b0}}, c_q}, lo_q};
    end else begin : g_single_add
        assign sum_full = top_q + bot_q;
    end

    always_comb begin
        prod  = neg_q[S-1] ? -sum_full : sum_full;
        res_d = '0;
        if (is_mul_op(f3_q[S-1])) begin
            res_d = (f3_q[S-1] == F3_MUL) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
        end else if (ld[S]) begin
            res_q <= res_d;
        end
    end

    assign out_valid  = v[S];
    assign out_result = res_q;
    assign out_tag    = tag_q[S];

`ifdef MUL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (out_valid && out_ready)  perf_ops   <= perf_ops + 32'd1;
            if (out_valid && !out_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
